sixteen_bit_multiplier: RTL and testbench
=========================================

SIXTEEN_BIT_MULTIPLIER -- requirements
Module: sixteen_bit_multiplier

Interface
REQ-001 SHALL have parameter bits, default 16, operand width; the product width is 2*bits.
REQ-002 SHALL have port Clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port Start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port A  input  bits  multiplicand, unsigned, captured when Start is accepted.
REQ-006 SHALL have port B  input  bits  multiplier, unsigned, captured when Start is accepted.
REQ-007 SHALL have port Busy  output  1  high in RUN and DONE.
REQ-008 SHALL have port Done  output  1  high for exactly one cycle when Product becomes valid.
REQ-009 SHALL have port Product  output  2*bits  unsigned A*B, held until the next accepted Start.

Function
REQ-010 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with Start=1 at a rising edge: latch A and B, clear the accumulator, load iteration counter = bits, go to RUN.
REQ-012 In IDLE with Start=0: stay in IDLE; Product, Busy and Done unchanged.
REQ-013 Each RUN cycle: if multiplier LSB = 1, add the multiplicand to the accumulator upper half with a bits-wide add including carry-out; otherwise add zero.
REQ-014 Each RUN cycle: shift {carry-out, accumulator, multiplier} right by one bit, then decrement the counter.
REQ-015 When the counter reaches 0 after the final iteration: go to DONE and load Product from the full 2*bits accumulator.
REQ-016 Latency: Start accepted at edge k means Done=1 and Product valid in the cycle after edge k+bits (16 cycles at default).
REQ-017 DONE lasts exactly one cycle, then unconditionally returns to IDLE; Done=1 only in DONE.
REQ-018 Start SHALL be ignored in RUN and DONE; operand registers SHALL not change.
REQ-019 Start held high continuously: the next multiply is accepted on the first edge in IDLE, so back-to-back throughput is one result per bits+2 cycles.
REQ-020 Arithmetic SHALL be exact modulo nothing: 0xFFFF*0xFFFF = 0xFFFE0001 with no lost carry.

Reset
REQ-021 Reset_n=0 SHALL asynchronously force state IDLE, Busy=0, Done=0, Product=0, counter=0, and clear operand and accumulator registers.
REQ-022 Reset asserted mid-RUN SHALL abort the operation; no Done pulse occurs for it.
REQ-023 After Reset_n deasserts, the first rising edge SHALL behave as IDLE.

Configuration
REQ-024 Macro ZERO_SKIP_EN SHALL enable early termination.
REQ-025 With ZERO_SKIP_EN defined: if A=0 or B=0 at acceptance, go IDLE -> DONE directly with Product=0, so Done appears in the cycle after the accepting edge.
REQ-026 Without ZERO_SKIP_EN: zero operands take the full bits iterations, like any other operands.
REQ-027 All other behaviour SHALL be identical with or without the macro.

Verification
REQ-028 A=3, B=5, Start pulse -> Done=1 exactly 16 cycles after the accepting edge, Product=0x0000000F; Busy high for 17 cycles.
REQ-029 A=0xFFFF, B=0xFFFF -> Product=0xFFFE0001; A=0x8000, B=0x0002 -> Product=0x00010000.
REQ-030 Start=1 with A=7, B=9 while in RUN of a 2*3 operation -> Product=6, operands unaffected; 7*9 is not computed unless Start is seen in IDLE.
REQ-031 Reset_n low for 1 cycle at the 8th RUN cycle -> Busy=0, Done=0, Product=0 immediately; no Done pulse follows.
REQ-032 A=0, B=0x1234 -> Product=0 with Done one cycle after acceptance when ZERO_SKIP_EN is defined, 16 cycles after when it is not.
REQ-033 Start held high for 3 operations -> Done pulses spaced exactly 18 cycles apart, each Product correct.

Source files
------------

// File: rtl/sixteen_bit_multiplier.sv
// Sequential shift-and-add unsigned multiplier: one partial product per RUN cycle.
// Define ZERO_SKIP_EN to finish immediately when either operand is zero.
module sixteen_bit_multiplier #(
    parameter int bits = 16
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Start,
    input  logic [bits-1:0]     A,
    input  logic [bits-1:0]     B,
    output logic                Busy,
    output logic                Done,
    output logic [2*bits-1:0]   Product
);

    localparam int CW = $clog2(bits + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_reg;
    logic [bits-1:0]       mcand_reg;
    logic [bits-1:0]       mult_reg;
    logic [bits-1:0]       acc_reg;
    logic [CW-1:0]         cnt_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [2*bits-1:0]     product_reg;

    logic [bits:0]         sum_next;
    logic [2*bits-1:0]     acc_next;

    // The carry-out becomes the new MSB, so no partial-product bit is lost.
    assign sum_next = {1'b0, acc_reg} + {1'b0, (mult_reg[0] ? mcand_reg : {bits{1'b0}})};
    assign acc_next = {sum_next, mult_reg[bits-1:1]};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg   <= IDLE;
            mcand_reg   <= '0;
            mult_reg    <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Start) begin
                        mcand_reg <= A;
                        mult_reg  <= B;
                        acc_reg   <= '0;
                        cnt_reg   <= CW'(bits);
                        busy_reg  <= 1'b1;
`ifdef ZERO_SKIP_EN
                        if (A == '0 || B == '0) begin
                            state_reg   <= DONE;
                            done_reg    <= 1'b1;
                            product_reg <= '0;
                        end else begin
                            state_reg <= RUN;
                        end
`else
                        state_reg <= RUN;
`endif
                    end
                end
                RUN: begin
                    acc_reg  <= acc_next[2*bits-1:bits];
                    mult_reg <= acc_next[bits-1:0];
                    cnt_reg  <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_reg   <= DONE;
                        done_reg    <= 1'b1;
                        product_reg <= acc_next;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_reg;
    assign Done    = done_reg;
    assign Product = product_reg;

endmodule

// File: tb/tb_sixteen_bit_multiplier.sv
// Scoreboard bench for sixteen_bit_multiplier: stimulus pushes expected results and
// completion cycles; a negedge monitor pops and compares on every Done pulse.
module tb_sixteen_bit_multiplier;

    localparam int BITS = 16;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b1;
    logic              Start = 1'b0;
    logic [BITS-1:0]   A = '0;
    logic [BITS-1:0]   B = '0;
    logic              Busy;
    logic              Done;
    logic [2*BITS-1:0] Product;

    sixteen_bit_multiplier #(.bits(BITS)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Product (Product)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic [2*BITS-1:0] prod;
        int                due;
        int                busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   next_free;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    endtask

    // Monitor: Done pulses are matched in order against the scoreboard.
    initial begin
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge Clock);
            if (!Reset_n) begin
                busy_cnt = 0;
            end else begin
                if (Busy) busy_cnt++;
                if (Done) begin
                    if (q.size() == 0) begin
                        check("spurious_done", longint'(Done), 0);
                    end else begin
                        e = q.pop_front();
                        check("product", longint'(Product), longint'(e.prod));
                        check("done_cycle", cyc, e.due);
                        check("busy_cycles", busy_cnt, e.busy);
                        $display("result prod=0x%08h at cycle %0d (due %0d)", Product, cyc, e.due);
                    end
                    busy_cnt = 0;
                end else if (q.size() > 0 && cyc > q[0].due) begin
                    check("done_timeout", longint'(Done), 1);
                    void'(q.pop_front());
                    busy_cnt = 0;
                end
            end
        end
    end

    // Reference: exact product in a 2*BITS-wide context; zero operands may skip.
    function automatic exp_t model(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int k);
        exp_t e;
        bit   skip;
`ifdef ZERO_SKIP_EN
        skip = (a == 0) || (b == 0);
`else
        skip = 1'b0;
`endif
        e.prod = {{BITS{1'b0}}, a} * {{BITS{1'b0}}, b};
        e.due  = skip ? k : k + BITS;
        e.busy = skip ? 1 : BITS + 1;
        return e;
    endfunction

    // Called at the negedge preceding an IDLE edge. mode: 0 idle, 1 Start held,
    // 2 random Start/operands during the run, 3 Start with 7*9 during the run.
    task automatic issue(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input int mode);
        exp_t e;
        int   k;
        A = a; B = b; Start = 1'b1;
        @(posedge Clock); #1;
        k = cyc;
        e = model(a, b, k);
        q.push_back(e);
        next_free = e.due + 2;
        $display("issue a=0x%04h b=0x%04h mode=%0d accepted at cycle %0d", a, b, mode, k);
        forever begin
            @(negedge Clock);
            if (cyc == next_free - 1) break;
            case (mode)
                1:       begin Start = 1'b1; A = BITS'($urandom); B = BITS'($urandom); end
                2:       begin Start = 1'($urandom); A = BITS'($urandom); B = BITS'($urandom); end
                3:       begin Start = 1'b1; A = 7; B = 9; end
                default: Start = 1'b0;
            endcase
        end
    endtask

    initial begin
        int k;
        int waited;
        logic [BITS-1:0] ra, rb;

        #2 Reset_n = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_busy", longint'(Busy), 0);
        check("reset_done", longint'(Done), 0);
        check("reset_product", longint'(Product), 0);
        #2 Reset_n = 1'b1;
        next_free = cyc + 1;

        issue(16'd3, 16'd5, 0);
        issue(16'hFFFF, 16'hFFFF, 2);
        issue(16'h8000, 16'h0002, 0);
        issue(16'd2, 16'd3, 3);
        issue(16'h0000, 16'h1234, 0);
        issue(16'h1234, 16'h0000, 0);
        issue(16'h0001, 16'hFFFF, 0);
        repeat (3) issue(BITS'($urandom), BITS'($urandom), 1);
        Start = 1'b0;

        // Abort a run during its 8th RUN cycle; no Done may follow.
        A = 16'h00AB; B = 16'h00CD; Start = 1'b1;
        @(posedge Clock); #1;
        k = cyc;
        Start = 1'b0;
        $display("issue a=0x00ab b=0x00cd (to be aborted) accepted at cycle %0d", k);
        do @(negedge Clock); while (cyc != k + 7);
        #2 Reset_n = 1'b0;
        #1;
        check("abort_busy", longint'(Busy), 0);
        check("abort_done", longint'(Done), 0);
        check("abort_product", longint'(Product), 0);
        @(negedge Clock);
        #2 Reset_n = 1'b1;
        next_free = cyc + 1;

        for (int i = 0; i < 20; i++) begin
            ra = BITS'($urandom);
            rb = BITS'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            issue(ra, rb, int'($urandom_range(0, 2)));
        end
        Start = 1'b0;

        waited = 0;
        while (q.size() > 0 && waited < 100) begin
            @(negedge Clock);
            waited++;
        end
        check("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
